// File: rtl/core_decode_pkg.sv
// Shared RV32I decode encodings, control-word layout and opcode constants.
// Used by rv32_decoder and decode_queue.
package core_decode_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_XOR  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_AND  = 4'h4,
        ALU_SLTU = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_EQ   = 4'hA,
        ALU_NE   = 4'hB,
        ALU_GEU  = 4'hC,
        ALU_GE   = 4'hD,
        ALU_JUMP = 4'hE,
        ALU_PASS = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZIMM = 2'd2
    } src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2 = 2'd0,
        SRC2_IMM = 2'd1,
        SRC2_CSR = 2'd2
    } src2_e;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2
    } mem_len_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2
    } wb_sel_e;

    // Declared MSB first; the offsets below follow this order.
    typedef struct packed {
        alu_op_e    alu_op;
        logic [1:0] alu_op2;
        src1_e      src1_sel;
        src2_e      src2_sel;
        logic       branch;
        logic       jump;
        mem_len_e   mem_len;
        logic       mem_wen_n;
        logic       rf_wen_n;
        logic       csr_wen_n;
        wb_sel_e    wb_sel;
        logic       load_sign;
        logic [3:0] md_op;
        logic       illegal;
        logic       ecall;
        logic       ebreak;
        logic       mret;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam int CTRL_MRET_LSB      = 0;
    localparam int CTRL_EBREAK_LSB    = 1;
    localparam int CTRL_ECALL_LSB     = 2;
    localparam int CTRL_ILLEGAL_LSB   = 3;
    localparam int CTRL_MD_OP_LSB     = 4;
    localparam int CTRL_LOAD_SIGN_LSB = 8;
    localparam int CTRL_WB_SEL_LSB    = 9;
    localparam int CTRL_CSR_WEN_N_LSB = 11;
    localparam int CTRL_RF_WEN_N_LSB  = 12;
    localparam int CTRL_MEM_WEN_N_LSB = 13;
    localparam int CTRL_MEM_LEN_LSB   = 14;
    localparam int CTRL_JUMP_LSB      = 16;
    localparam int CTRL_BRANCH_LSB    = 17;
    localparam int CTRL_SRC2_SEL_LSB  = 18;
    localparam int CTRL_SRC1_SEL_LSB  = 20;
    localparam int CTRL_ALU_OP2_LSB   = 22;
    localparam int CTRL_ALU_OP_LSB    = 24;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    localparam ctrl_t CTRL_IDLE = '{
        alu_op:    ALU_ADD,
        alu_op2:   2'b00,
        src1_sel:  SRC1_RS1,
        src2_sel:  SRC2_RS2,
        branch:    1'b0,
        jump:      1'b0,
        mem_len:   LEN_B,
        mem_wen_n: 1'b1,
        rf_wen_n:  1'b1,
        csr_wen_n: 1'b1,
        wb_sel:    WB_ALU,
        load_sign: 1'b0,
        md_op:     4'h0,
        illegal:   1'b0,
        ecall:     1'b0,
        ebreak:    1'b0,
        mret:      1'b0
    };

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I instruction decoder; RV32M decode when RV32M_EN is defined.
// Illegal words come out as an idle control word with only illegal set.
module rv32_decoder
    import core_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       ill;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    function automatic alu_op_e alu_of(input logic [2:0] fn, input logic alt);
        alu_op_e r;
        case (fn)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        c   = CTRL_IDLE;
        ill = 1'b0;
        case (opc)
            OPC_LUI: begin
                c.alu_op   = ALU_PASS;
                c.src2_sel = SRC2_IMM;
                c.wb_sel   = WB_IMM;
                c.rf_wen_n = 1'b0;
            end
            OPC_AUIPC: begin
                c.src1_sel = SRC1_PC;
                c.src2_sel = SRC2_IMM;
                c.rf_wen_n = 1'b0;
            end
            OPC_JAL: begin
                c.alu_op   = ALU_JUMP;
                c.jump     = 1'b1;
                c.src1_sel = SRC1_PC;
                c.src2_sel = SRC2_IMM;
                c.rf_wen_n = 1'b0;
            end
            OPC_JALR: begin
                c.alu_op   = ALU_JUMP;
                c.jump     = 1'b1;
                c.src2_sel = SRC2_IMM;
                c.rf_wen_n = 1'b0;
                ill        = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.branch = 1'b1;
                case (f3)
                    3'b000:  c.alu_op = ALU_EQ;
                    3'b001:  c.alu_op = ALU_NE;
                    3'b100:  c.alu_op = ALU_SLT;
                    3'b101:  c.alu_op = ALU_GE;
                    3'b110:  c.alu_op = ALU_SLTU;
                    3'b111:  c.alu_op = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.src2_sel  = SRC2_IMM;
                c.wb_sel    = WB_MEM;
                c.rf_wen_n  = 1'b0;
                c.mem_len   = mem_len_e'(f3[1:0]);
                c.load_sign = ~f3[2];
                ill = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
            end
            OPC_STORE: begin
                c.src2_sel  = SRC2_IMM;
                c.mem_wen_n = 1'b0;
                c.mem_len   = mem_len_e'(f3[1:0]);
                ill         = (f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                c.src2_sel = SRC2_IMM;
                c.rf_wen_n = 1'b0;
                c.alu_op   = alu_of(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001) ill = (f7 != 7'h00);
                if (f3 == 3'b101) ill = ((f7 & ~7'h20) != 7'h00);
            end
            OPC_OP: begin
                c.rf_wen_n = 1'b0;
                if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    c.md_op = {1'b1, f3};
`else
                    ill = 1'b1;
`endif
                end else begin
                    c.alu_op = alu_of(f3, f7[5]);
                    ill = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101)));
                end
            end
            OPC_MISC_MEM: begin
                c = CTRL_IDLE;
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    c.ecall  = (instr_i == INSTR_ECALL);
                    c.ebreak = (instr_i == INSTR_EBREAK);
                    c.mret   = (instr_i == INSTR_MRET);
                    ill      = !(c.ecall || c.ebreak || c.mret);
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else begin
                    c.alu_op    = ALU_PASS;
                    c.alu_op2   = f3[1:0];
                    c.src1_sel  = f3[2] ? SRC1_ZIMM : SRC1_RS1;
                    c.src2_sel  = SRC2_CSR;
                    c.csr_wen_n = 1'b0;
                    c.rf_wen_n  = 1'b0;
                end
            end
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        ctrl_o = c;
        if (ill) begin
            ctrl_o         = CTRL_IDLE;
            ctrl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry FIFO toward execute, with flush,
// occupancy and a saturating illegal counter. RV32M_EN enables RV32M decode.
module decode_queue
    import core_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [PC_W-1:0]          in_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CTRL_W-1:0]        out_ctrl_o,
    output logic [31:0]              out_instr_o,
    output logic [PC_W-1:0]          out_pc_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         illegal_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    ctrl_t dec_ctrl;

    logic [CTRL_W-1:0] ctrl_mem_q  [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem_d  [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];
    logic [31:0]       instr_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q    [DEPTH];
    logic [PC_W-1:0]   pc_mem_d    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ill_q, ill_d;
    logic             push, pop;

    rv32_decoder u_dec (
        .instr_i (in_instr_i),
        .ctrl_o  (dec_ctrl)
    );

    // Ready depends only on stored occupancy, never on out_ready_i.
    assign in_ready_o    = (cnt_q != FULL);
    assign out_valid_o   = (cnt_q != '0);
    assign count_o       = cnt_q;
    assign illegal_cnt_o = ill_q;
    assign out_ctrl_o    = out_valid_o ? ctrl_mem_q[rd_ptr_q]  : '0;
    assign out_instr_o   = out_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc_o      = out_valid_o ? pc_mem_q[rd_ptr_q]    : '0;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ill_d       = ill_q;
        ctrl_mem_d  = ctrl_mem_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                ctrl_mem_d[wr_ptr_q]  = dec_ctrl;
                instr_mem_d[wr_ptr_q] = in_instr_i;
                pc_mem_d[wr_ptr_q]    = in_pc_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) cnt_d = cnt_q + OCC_W'(1);
            if (pop && !push) cnt_d = cnt_q - OCC_W'(1);
        end
        if (push && dec_ctrl.illegal && (ill_q != {CNT_W{1'b1}}))
            ill_d = ill_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ill_q       <= '0;
            ctrl_mem_q  <= '{default: '0};
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ill_q       <= ill_d;
            ctrl_mem_q  <= ctrl_mem_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: directed scenarios plus randomized traffic
// against a queue-based reference model with its own decode function.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_instr_i;
    logic [PC_W-1:0]   in_pc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [27:0]       out_ctrl_o;
    logic [31:0]       out_instr_o;
    logic [PC_W-1:0]   out_pc_o;
    logic [2:0]        count_o;
    logic [CNT_W-1:0]  illegal_cnt_o;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_instr_i    (in_instr_i),
        .in_pc_i       (in_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_ctrl_o    (out_ctrl_o),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .count_o       (count_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [27:0] q_ctrl[$];
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    int          m_ill = 0;

    function automatic logic [27:0] ref_decode(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int alu, a2, s1, s2, br, jp, len, mw, rw, cw, wb, ls, md, ec, eb, mr;
        bit il;
        int br_tab[8];
        int op_tab[8];
        br_tab = '{10, 11, -1, -1, 6, 13, 5, 12};
        op_tab = '{0, 7, 6, 5, 2, 8, 3, 4};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        alu = 0; a2 = 0; s1 = 0; s2 = 0; br = 0; jp = 0; len = 0;
        mw = 1; rw = 1; cw = 1; wb = 0; ls = 0; md = 0;
        ec = 0; eb = 0; mr = 0; il = 0;
        case (op)
            7'h37: begin alu = 15; s2 = 1; wb = 2; rw = 0; end
            7'h17: begin s1 = 1; s2 = 1; rw = 0; end
            7'h6F: begin alu = 14; jp = 1; s1 = 1; s2 = 1; rw = 0; end
            7'h67: begin alu = 14; jp = 1; s2 = 1; rw = 0; il = (f3 != 0); end
            7'h63: begin br = 1; alu = br_tab[f3]; il = (alu < 0); end
            7'h03: begin
                s2 = 1; wb = 1; rw = 0; len = f3 & 3; ls = (f3 < 4);
                il = (f3 == 3 || f3 > 5);
            end
            7'h23: begin s2 = 1; mw = 0; len = f3 & 3; il = (f3 > 2); end
            7'h13: begin
                s2 = 1; rw = 0; alu = op_tab[f3];
                if (f3 == 1) il = (f7 != 0);
                if (f3 == 5) begin
                    il = !(f7 == 0 || f7 == 7'h20);
                    if (f7 == 7'h20) alu = 9;
                end
            end
            7'h33: begin
                rw = 0;
                if (f7 == 1) begin
`ifdef RV32M_EN
                    md = 8 + f3;
`else
                    il = 1;
`endif
                end else begin
                    alu = op_tab[f3];
                    if (f7 == 7'h20 && f3 == 0) alu = 1;
                    else if (f7 == 7'h20 && f3 == 5) alu = 9;
                    else il = (f7 != 0);
                end
            end
            7'h0F: begin end
            7'h73: begin
                if (f3 == 0) begin
                    if (w == 32'h0000_0073) ec = 1;
                    else if (w == 32'h0010_0073) eb = 1;
                    else if (w == 32'h3020_0073) mr = 1;
                    else il = 1;
                end else if (f3 == 4) begin
                    il = 1;
                end else begin
                    alu = 15; a2 = f3 & 3; s1 = (f3 > 4) ? 2 : 0;
                    s2 = 2; cw = 0; rw = 0;
                end
            end
            default: il = 1;
        endcase
        if (il) return 28'h000_3808;
        return {4'(alu), 2'(a2), 2'(s1), 2'(s2), 1'(br), 1'(jp),
                2'(len), 1'(mw), 1'(rw), 1'(cw), 2'(wb), 1'(ls),
                4'(md), 1'b0, 1'(ec), 1'(eb), 1'(mr)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 64'(count_o), 64'(q_ctrl.size()));
        chk("in_ready", 64'(in_ready_o), 64'(q_ctrl.size() != DEPTH));
        chk("out_valid", 64'(out_valid_o), 64'(q_ctrl.size() != 0));
        chk("ill_cnt", 64'(illegal_cnt_o), 64'(m_ill));
        if (q_ctrl.size() != 0) begin
            chk("head_ctrl", 64'(out_ctrl_o), 64'(q_ctrl[0]));
            chk("head_instr", 64'(out_instr_o), 64'(q_instr[0]));
            chk("head_pc", 64'(out_pc_o), 64'(q_pc[0]));
        end else begin
            chk("idle_data", {out_ctrl_o, out_instr_o[3:0], out_pc_o}, 64'h0);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic rdy,
                         input logic fl);
        bit do_push, do_pop;
        logic [27:0] c;
        in_valid_i  = v;
        in_instr_i  = ins;
        in_pc_i     = pc;
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
        check_outputs();
        do_push = v && (q_ctrl.size() < DEPTH) && !fl;
        do_pop  = (q_ctrl.size() > 0) && rdy && !fl;
        c = ref_decode(ins);
        @(posedge clk_i);
        #1;
        if (fl) begin
            q_ctrl.delete();
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (do_pop) begin
                void'(q_ctrl.pop_front());
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (do_push) begin
                q_ctrl.push_back(c);
                q_instr.push_back(ins);
                q_pc.push_back(pc);
                if (c[3] && m_ill < SAT) m_ill++;
            end
        end
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        #2;
        q_ctrl.delete();
        q_instr.delete();
        q_pc.delete();
        m_ill = 0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [6:0]  ops[11];
        logic [31:0] r, ins, pc;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        reset_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_instr_i  = '0;
        in_pc_i     = '0;
        out_ready_i = 1'b0;
        #12;
        check_outputs();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset with three entries held, one of them illegal
        cycle(1'b1, 32'h0010_0093, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 32'h14, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0093, 32'h18, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        chk("pre_rst_ill", 64'(illegal_cnt_o), 64'd1);
        reset_i = 1'b0;
        #2;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_ill", 64'(illegal_cnt_o), 64'd0);
        do_reset();

        // ADDI x1, x0, 5
        cycle(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        chk("addi_valid", 64'(out_valid_o), 64'd1);
        chk("addi_alu", 64'(out_ctrl_o[27:24]), 64'h0);
        chk("addi_src2", 64'(out_ctrl_o[19:18]), 64'h1);
        chk("addi_rfwen", 64'(out_ctrl_o[12]), 64'h0);
        chk("addi_illegal", 64'(out_ctrl_o[3]), 64'h0);
        drain();

        // Fill past DEPTH with execute stalled
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h0000_0093 | (32'(i) << 20), 32'h200 + 32'(4 * i),
                  1'b0, 1'b0);
            if (i == 3) chk("full_ready", 64'(in_ready_o), 64'd0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ready_after_pop", 64'(in_ready_o), 64'd1);
        drain();

        // Flush with a same-cycle push
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h0000_0033, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h00A0_0093, 32'hBAD0, 1'b1, 1'b1);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        cycle(1'b1, 32'h0030_0093, 32'h400, 1'b0, 1'b0);
        chk("post_flush_pc", 64'(out_pc_o), 64'h400);
        drain();

        // MUL x0, x1, x2
        do_reset();
        cycle(1'b1, 32'h0220_8033, 32'h500, 1'b0, 1'b0);
`ifdef RV32M_EN
        chk("mul_illegal", 64'(out_ctrl_o[3]), 64'd0);
        chk("mul_md_op", 64'(out_ctrl_o[7:4]), 64'h8);
        chk("mul_ill_cnt", 64'(illegal_cnt_o), 64'd0);
`else
        chk("mul_illegal", 64'(out_ctrl_o[3]), 64'd1);
        chk("mul_md_op", 64'(out_ctrl_o[7:4]), 64'h0);
        chk("mul_ill_cnt", 64'(illegal_cnt_o), 64'd1);
`endif
        drain();

        // ECALL followed by SYSTEM funct3=100
        cycle(1'b1, 32'h0000_0073, 32'h600, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_4073, 32'h604, 1'b0, 1'b0);
        chk("ecall_bit", 64'(out_ctrl_o[2]), 64'd1);
        chk("ecall_illegal", 64'(out_ctrl_o[3]), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sys4_illegal", 64'(out_ctrl_o[3]), 64'd1);
        chk("sys4_csr_wen_n", 64'(out_ctrl_o[11]), 64'd1);
        drain();

        // Counter saturation under streaming push+pop
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'hFFFF_FFFF, 32'h700 + 32'(4 * i), 1'b1, 1'b0);
        chk("ill_saturated", 64'(illegal_cnt_o), 64'(SAT));
        drain();

        do_reset();
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            ins = $urandom;
            if ($urandom_range(0, 99) < 85)
                ins[6:0] = ops[$urandom_range(0, 10)];
            if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
                case ($urandom_range(0, 3))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    2: ins[31:25] = 7'h01;
                    default: ;
                endcase
            end
            if (ins[6:0] == 7'h73 && r[3:2] == 2'b00) begin
                case (r[5:4])
                    2'd0: ins = 32'h0000_0073;
                    2'd1: ins = 32'h0010_0073;
                    2'd2: ins = 32'h3020_0073;
                    default: ;
                endcase
            end
            cycle(r[31:29] != 3'b000, ins, pc, r[28:27] != 2'b00,
                  r[26:22] == 5'd0);
            pc = pc + 4;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
